score_counter: RTL

Downstream consumer of the 9 Hz `score_tick` square wave produced by the score clock divider. Detects rising edges of `score_tick` while a round is running and accumulates a packed-BCD score that the OLED renderer draws directly. Freezes the score at game over, optionally maintains a high score, and emits a milestone pulse every 100 points for the obstacle speed-up logic.

---
 rtl/score_counter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/score_counter.sv
// score_counter: counts rising edges of score_tick during a round into a
// packed-BCD score, freezes it at game over, keeps an optional high score
// and pulses milestone each time digit MILESTONE_DIGIT increments.
// Optional feature macro: SCORE_HISCORE_EN (high-score register, compare
// and new_high). When undefined, hiscore and new_high are tied to 0.
module score_counter #(
  parameter int unsigned DIGITS          = 4,
  parameter int unsigned MILESTONE_DIGIT = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                score_tick,
  input  logic                gameon,
  output logic [4*DIGITS-1:0] score,
  output logic [4*DIGITS-1:0] hiscore,
  output logic                new_high,
  output logic                milestone,
  output logic                saturated,
  output logic                running
);

  localparam int unsigned W = 4 * DIGITS;
  localparam logic [W-1:0] ALL9 = {DIGITS{4'h9}};

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_CMP  = 2'b10;
  localparam logic [1:0] ST_OVER = 2'b11;

  logic [1:0]   r_state;
  logic         r_tick_q;
  logic [W-1:0] r_score;
  logic         r_milestone;
  logic         r_saturated;
  logic         r_running;

  logic [1:0]   w_state_nxt;
  logic [W-1:0] w_score_nxt;
  logic         w_milestone_nxt;
  logic [W-1:0] w_score_inc;
  logic         w_carry;
  logic         w_tick_rise;
  logic         w_ms_change;

`ifdef SCORE_HISCORE_EN
  logic [W-1:0] r_hiscore;
  logic         r_new_high;
  logic [W-1:0] w_hiscore_nxt;
  logic         w_new_high_nxt;
`endif

  assign w_tick_rise = score_tick & ~r_tick_q;
  assign w_ms_change = (w_score_inc[4*MILESTONE_DIGIT +: 4] != r_score[4*MILESTONE_DIGIT +: 4]);

  // BCD +1 with digit ripple carry
  always_comb begin
    w_score_inc = r_score;
    w_carry     = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (w_carry) begin
        if (r_score[4*i +: 4] == 4'd9) begin
          w_score_inc[4*i +: 4] = 4'd0;
        end else begin
          w_score_inc[4*i +: 4] = r_score[4*i +: 4] + 4'd1;
          w_carry               = 1'b0;
        end
      end
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt     = r_state;
    w_score_nxt     = r_score;
    w_milestone_nxt = 1'b0;
`ifdef SCORE_HISCORE_EN
    w_hiscore_nxt   = r_hiscore;
    w_new_high_nxt  = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        w_score_nxt = '0;
        if (gameon) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (!gameon) begin
          w_state_nxt = ST_CMP;
        end else if (w_tick_rise && (r_score != ALL9)) begin
          w_score_nxt     = w_score_inc;
          w_milestone_nxt = w_ms_change;
        end
      end
      ST_CMP: begin
`ifdef SCORE_HISCORE_EN
        // Packed BCD orders the same as its decimal value
        if (r_score > r_hiscore) begin
          w_hiscore_nxt  = r_score;
          w_new_high_nxt = 1'b1;
        end
`endif
        w_state_nxt = ST_OVER;
      end
      default: begin
        if (gameon) begin
          w_state_nxt = ST_RUN;
          w_score_nxt = '0;
        end
      end
    endcase
  end

  // State and output registers, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_tick_q    <= 1'b0;
      r_score     <= '0;
      r_milestone <= 1'b0;
      r_saturated <= 1'b0;
      r_running   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_tick_q    <= score_tick;
      r_score     <= w_score_nxt;
      r_milestone <= w_milestone_nxt;
      r_saturated <= (w_score_nxt == ALL9);
      r_running   <= (w_state_nxt == ST_RUN);
    end
  end

`ifdef SCORE_HISCORE_EN
  // High-score register, updated only from the compare cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hiscore  <= '0;
      r_new_high <= 1'b0;
    end else begin
      r_hiscore  <= w_hiscore_nxt;
      r_new_high <= w_new_high_nxt;
    end
  end

  assign hiscore  = r_hiscore;
  assign new_high = r_new_high;
`else
  assign hiscore  = '0;
  assign new_high = 1'b0;
`endif

  assign score     = r_score;
  assign milestone = r_milestone;
  assign saturated = r_saturated;
  assign running   = r_running;

endmodule
